vend_panel_arbiter: RTL and testbench
=====================================

# vend_panel_arbiter

Shares one `vending_machine` core between `N_PANEL` customer front panels. Grants the core to one panel per session and forwards that panel's selection and coin strobes to the core. Routes `done`, `error` and change pulses back to the granted panel. A watchdog force-resets the core when a session stalls. Sits between the panel I/O logic and the vending core.

## Interface
Parameters:
- `N_PANEL`, default 4: number of panels, 2..8.
- `TIMEOUT`, default 255: SESSION cycles without a coin or `vm_done` before abort, ≥ 40.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, **asynchronous, active-low**.
- `req` in N_PANEL: level session request per panel.
- `panel_sel` in 2·N_PANEL: product select per panel. Panel i uses bits [2i+1:2i].
- `panel_one`, `panel_two`, `panel_five` in N_PANEL: one-cycle coin strobes per panel.
- `vm_done` in 1: core `done`.
- `vm_error` in 1: core `error`.
- `vm_en_change` in 1: core `en_change`.
- `vm_start` out 1: core `start`.
- `vm_sel` out 2: core `sel`.
- `vm_en_one`, `vm_en_two`, `vm_en_five` out 1: core coin enables.
- `vm_rst` out 1: active-low synchronous reset to the core.
- `grant` out N_PANEL: one-hot owner of the core. All zero when the core is free.
- `panel_done` out N_PANEL: one-cycle session-complete pulse.
- `panel_error` out N_PANEL: one-cycle error/abort pulse.
- `panel_change` out N_PANEL: change pulses to the owner. Equals `grant & {N_PANEL{vm_en_change}}` (combinational).
- `busy` out 1: high in every state except IDLE.

## Operation
FSM states: IDLE, START, SESSION, ABORT, RELEASE.
- **IDLE**
  - With `req` ≠ 0: pick the winner g, set `grant[g]`, latch `vm_sel ← panel_sel[g]`, go to START.
  - With `req` = 0: stay.
  - Winner g is the first set `req` bit at or after round-robin pointer `ptr`, searching upward with wrap.
- **START**
  - `vm_start` = 1 for exactly this cycle.
  - Clear the watchdog. Go to SESSION.
- **SESSION**
  - Forward coins registered: `vm_en_x ← panel_x[g]`, 1-cycle latency.
  - Coin strobes from non-granted panels are dropped.
  - Any forwarded coin clears the watchdog. Otherwise it increments.
  - On `vm_done`: pulse `panel_done[g]`. Also pulse `panel_error[g]` if `vm_error` = 1. Go to RELEASE.
  - On watchdog = TIMEOUT without `vm_done`: pulse `panel_error[g]`, go to ABORT.
  - If `vm_done` and watchdog expiry coincide, `vm_done` wins.
- **ABORT**
  - `vm_rst` = 0 for 2 cycles (internal 1-bit counter).
  - Coin forwarding off. Go to RELEASE.
- **RELEASE**
  - `grant` ← 0.
  - `ptr ← (g+1) mod N_PANEL`.
  - `vm_sel` holds its value. Go to IDLE.
- `vm_sel` stays stable from START through RELEASE.
- `req` deassertion after the grant is ignored. The session runs to completion.
- `ptr` is $clog2(N_PANEL) bits. The watchdog is $clog2(TIMEOUT+1) bits and saturates, with no wrap.

## Timing
Reset values:
- State = IDLE, `ptr` = 0.
- `grant`, `panel_done`, `panel_error` = 0.
- `vm_start`, `vm_en_*`, watchdog = 0. `vm_sel` = 2'b00.
- `vm_rst` = 1, `busy` = 0.

Asserting `rst` mid-session:
- Returns the block to IDLE immediately and drops `grant`.
- Does not pulse `vm_rst`. The system reset covers the core.

Latencies:
- `req` to `grant`: 1 edge.
- `grant` to `vm_start` high: the same cycle as START, 1 cycle after the grant edge.
- Panel coin to `vm_en_x`: 1 cycle.
- `vm_done` to `panel_done`: 1 cycle.
- `vm_done` to next grant possible: 3 cycles (SESSION→RELEASE→IDLE→grant).
- `panel_change` has zero latency from `vm_en_change`.

## Configuration
- `VEND_ARB_PRIORITY_EN` defined:
  - Fixed priority. The lowest-index set `req` wins.
  - `ptr` is not implemented.
- `VEND_ARB_PRIORITY_EN` undefined (default):
  - Round-robin as described in Operation.

## Test plan
- Single session:
  - Stimulus: `req`=4'b0010, `panel_sel[3:2]`=2'b01, then panel 1 pulses `panel_two` once.
  - Response: `grant`=0010, one `vm_start` pulse with `vm_sel`=01, `vm_en_two` one cycle later.
  - Response: `panel_done[1]` pulses 1 cycle after `vm_done`; `grant` returns to 0000.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held for 4 sessions.
  - Response: grants in order 0001, 0010, 0100, 1000.
  - With `VEND_ARB_PRIORITY_EN`: every grant is 0001.
- Coin isolation:
  - Stimulus: panel 2 pulses `panel_five` during panel 0's session.
  - Response: no `vm_en_five` pulse.
- Watchdog:
  - Stimulus: grant, then no coins and no `vm_done` for 255 cycles.
  - Response: `panel_error[g]` pulses, `vm_rst` is low for exactly 2 cycles, `grant` clears.
- Done/timeout race:
  - Stimulus: `vm_done` arrives on the expiry cycle.
  - Response: `panel_done` pulses, no `vm_rst` pulse.
- Async reset:
  - Stimulus: assert `rst` mid-SESSION between clock edges.
  - Response: `grant`, `busy`, `vm_en_*` go to 0 before the next edge.

Source files
------------

// File: rtl/vend_panel_arbiter.sv
// vend_panel_arbiter: shares one vending core between N_PANEL front panels, one session at a time.
// Define VEND_ARB_PRIORITY_EN for fixed lowest-index priority; default build is round-robin.
module vend_panel_arbiter #(
   parameter int N_PANEL = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_PANEL-1:0]     req,
   input  logic [2*N_PANEL-1:0]   panel_sel,
   input  logic [N_PANEL-1:0]     panel_one,
   input  logic [N_PANEL-1:0]     panel_two,
   input  logic [N_PANEL-1:0]     panel_five,
   input  logic                   vm_done,
   input  logic                   vm_error,
   input  logic                   vm_en_change,
   output logic                   vm_start,
   output logic [1:0]             vm_sel,
   output logic                   vm_en_one,
   output logic                   vm_en_two,
   output logic                   vm_en_five,
   output logic                   vm_rst,
   output logic [N_PANEL-1:0]     grant,
   output logic [N_PANEL-1:0]     panel_done,
   output logic [N_PANEL-1:0]     panel_error,
   output logic [N_PANEL-1:0]     panel_change,
   output logic                   busy
);
   localparam int PW = $clog2(N_PANEL);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0]      WD_MAX = WW'(TIMEOUT);
   localparam logic [N_PANEL-1:0] ONE_HOT0 = {{(N_PANEL-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_SESSION = 3'd2,
      S_ABORT   = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        idx_q, idx_d;
   logic [N_PANEL-1:0]   grant_q, grant_d;
   logic [1:0]           sel_q, sel_d;
   logic                 start_q, start_d;
   logic                 en_one_q, en_one_d;
   logic                 en_two_q, en_two_d;
   logic                 en_five_q, en_five_d;
   logic                 vmrst_q, vmrst_d;
   logic [N_PANEL-1:0]   done_q, done_d;
   logic [N_PANEL-1:0]   err_q, err_d;
   logic [WW-1:0]        wd_q, wd_d;
   logic                 abort_q, abort_d;
   logic [PW-1:0]        win_s;
   logic                 coin_s;
`ifndef VEND_ARB_PRIORITY_EN
   logic [PW-1:0]        ptr_q, ptr_d;
`endif

   // Winner selection: scan downward so the lowest offset from the search origin is kept last.
   always_comb begin
      win_s = {PW{1'b0}};
      for (int k = N_PANEL - 1; k >= 0; k--) begin
`ifdef VEND_ARB_PRIORITY_EN
         win_s = req[k] ? PW'(k) : win_s;
`else
         win_s = req[PW'((int'(ptr_q) + k) % N_PANEL)] ? PW'((int'(ptr_q) + k) % N_PANEL) : win_s;
`endif
      end
   end

   // Next-state and next-output computation for the session FSM.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      start_d   = 1'b0;
      en_one_d  = 1'b0;
      en_two_d  = 1'b0;
      en_five_d = 1'b0;
      vmrst_d   = 1'b1;
      done_d    = {N_PANEL{1'b0}};
      err_d     = {N_PANEL{1'b0}};
      wd_d      = wd_q;
      abort_d   = abort_q;
      coin_s    = 1'b0;
`ifndef VEND_ARB_PRIORITY_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req != {N_PANEL{1'b0}}) begin
               idx_d   = win_s;
               grant_d = ONE_HOT0 << win_s;
               sel_d   = panel_sel[2*int'(win_s) +: 2];
               start_d = 1'b1;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            wd_d    = {WW{1'b0}};
            state_d = S_SESSION;
         end
         S_SESSION: begin
            en_one_d  = panel_one[idx_q];
            en_two_d  = panel_two[idx_q];
            en_five_d = panel_five[idx_q];
            coin_s    = panel_one[idx_q] | panel_two[idx_q] | panel_five[idx_q];
            if (coin_s) begin
               wd_d = {WW{1'b0}};
            end else if (wd_q != WD_MAX) begin
               wd_d = wd_q + WW'(1);
            end else begin
               wd_d = wd_q;
            end
            // A done arriving on the expiry cycle takes precedence over the abort.
            if (vm_done) begin
               done_d  = grant_q;
               err_d   = vm_error ? grant_q : {N_PANEL{1'b0}};
               state_d = S_RELEASE;
            end else if (wd_q == WD_MAX) begin
               err_d   = grant_q;
               vmrst_d = 1'b0;
               abort_d = 1'b0;
               state_d = S_ABORT;
            end else begin
               state_d = S_SESSION;
            end
         end
         S_ABORT: begin
            if (!abort_q) begin
               abort_d = 1'b1;
               vmrst_d = 1'b0;
               state_d = S_ABORT;
            end else begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            grant_d = {N_PANEL{1'b0}};
`ifndef VEND_ARB_PRIORITY_EN
            ptr_d   = PW'((int'(idx_q) + 1) % N_PANEL);
`endif
            state_d = S_IDLE;
         end
         default: begin
            grant_d = {N_PANEL{1'b0}};
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= {PW{1'b0}};
         grant_q   <= {N_PANEL{1'b0}};
         sel_q     <= 2'b00;
         start_q   <= 1'b0;
         en_one_q  <= 1'b0;
         en_two_q  <= 1'b0;
         en_five_q <= 1'b0;
         vmrst_q   <= 1'b1;
         done_q    <= {N_PANEL{1'b0}};
         err_q     <= {N_PANEL{1'b0}};
         wd_q      <= {WW{1'b0}};
         abort_q   <= 1'b0;
`ifndef VEND_ARB_PRIORITY_EN
         ptr_q     <= {PW{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         start_q   <= start_d;
         en_one_q  <= en_one_d;
         en_two_q  <= en_two_d;
         en_five_q <= en_five_d;
         vmrst_q   <= vmrst_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wd_q      <= wd_d;
         abort_q   <= abort_d;
`ifndef VEND_ARB_PRIORITY_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign vm_start     = start_q;
   assign vm_sel       = sel_q;
   assign vm_en_one    = en_one_q;
   assign vm_en_two    = en_two_q;
   assign vm_en_five   = en_five_q;
   assign vm_rst       = vmrst_q;
   assign grant        = grant_q;
   assign panel_done   = done_q;
   assign panel_error  = err_q;
   assign panel_change = grant_q & {N_PANEL{vm_en_change}};
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Directed bench for vend_panel_arbiter (default round-robin build, N_PANEL=4, TIMEOUT=255).
module tb_vend_panel_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] panel_sel;
   logic [3:0] panel_one, panel_two, panel_five;
   logic       vm_done, vm_error, vm_en_change;
   logic       vm_start, vm_en_one, vm_en_two, vm_en_five, vm_rst, busy;
   logic [1:0] vm_sel;
   logic [3:0] grant, panel_done, panel_error, panel_change;

   int n_checks = 0;
   int n_fails  = 0;

   vend_panel_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .panel_sel(panel_sel),
      .panel_one(panel_one), .panel_two(panel_two), .panel_five(panel_five),
      .vm_done(vm_done), .vm_error(vm_error), .vm_en_change(vm_en_change),
      .vm_start(vm_start), .vm_sel(vm_sel), .vm_en_one(vm_en_one),
      .vm_en_two(vm_en_two), .vm_en_five(vm_en_five), .vm_rst(vm_rst),
      .grant(grant), .panel_done(panel_done), .panel_error(panel_error),
      .panel_change(panel_change), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One short session for whichever panel wins; exp_g is the expected one-hot grant.
   task automatic rr_session(input logic [3:0] exp_g);
      tick();
      check("rr_grant", 32'(grant), 32'(exp_g));
      tick();
      vm_done = 1'b1;
      tick();
      vm_done = 1'b0;
      check("rr_done", 32'(panel_done), 32'(exp_g));
      tick();
      check("rr_release", 32'(grant), 32'h0);
   endtask

   initial begin
      req = 4'b0000; panel_sel = 8'h00;
      panel_one = 4'b0000; panel_two = 4'b0000; panel_five = 4'b0000;
      vm_done = 1'b0; vm_error = 1'b0; vm_en_change = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_vm_rst", 32'(vm_rst), 32'h1);
      check("rst_start", 32'(vm_start), 32'h0);
      check("rst_sel", 32'(vm_sel), 32'h0);
      check("rst_done", 32'(panel_done), 32'h0);
      check("rst_error", 32'(panel_error), 32'h0);
      check("rst_en", 32'({vm_en_one, vm_en_two, vm_en_five}), 32'h0);
      rst = 1'b1;

      // Round-robin from ptr=0 with all panels requesting.
      req = 4'b1111;
      rr_session(4'b0001);
      rr_session(4'b0010);
      rr_session(4'b0100);
      rr_session(4'b1000);
      req = 4'b0000;
      tick();
      check("idle_no_req", 32'(grant), 32'h0);

      // Single session for panel 1, product 01, one 'two' coin.
      req = 4'b0010; panel_sel = 8'b0000_0100;
      tick();
      check("s1_grant", 32'(grant), 32'h2);
      check("s1_start", 32'(vm_start), 32'h1);
      check("s1_sel", 32'(vm_sel), 32'h1);
      check("s1_busy", 32'(busy), 32'h1);
      req = 4'b0000; panel_sel = 8'h00;
      tick();
      check("s1_start_off", 32'(vm_start), 32'h0);
      check("s1_grant_held", 32'(grant), 32'h2);
      check("s1_sel_held", 32'(vm_sel), 32'h1);
      panel_two = 4'b0010;
      tick();
      panel_two = 4'b0000;
      check("s1_en_two", 32'(vm_en_two), 32'h1);
      tick();
      check("s1_en_two_off", 32'(vm_en_two), 32'h0);
      vm_en_change = 1'b1;
      #1;
      check("s1_change", 32'(panel_change), 32'h2);
      vm_en_change = 1'b0;
      #1;
      check("s1_change_off", 32'(panel_change), 32'h0);
      vm_done = 1'b1;
      tick();
      vm_done = 1'b0;
      check("s1_done", 32'(panel_done), 32'h2);
      check("s1_err", 32'(panel_error), 32'h0);
      tick();
      check("s1_done_off", 32'(panel_done), 32'h0);
      check("s1_release", 32'(grant), 32'h0);
      check("s1_idle", 32'(busy), 32'h0);

      // Coin isolation: panel 0 owns the core (ptr=2 but only panel 0 asks).
      req = 4'b0001;
      tick();
      check("iso_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      tick();
      panel_five = 4'b0100;
      tick();
      panel_five = 4'b0000;
      check("iso_drop", 32'(vm_en_five), 32'h0);
      panel_five = 4'b0001;
      tick();
      panel_five = 4'b0000;
      check("iso_own", 32'(vm_en_five), 32'h1);
      vm_done = 1'b1; vm_error = 1'b1;
      tick();
      vm_done = 1'b0; vm_error = 1'b0;
      check("iso_done", 32'(panel_done), 32'h1);
      check("iso_err", 32'(panel_error), 32'h1);
      tick();
      check("iso_release", 32'(grant), 32'h0);

      // Watchdog: ptr=1, panel 2 is granted and then idles.
      req = 4'b0100;
      tick();
      check("wd_grant", 32'(grant), 32'h4);
      req = 4'b0000;
      tick();
      repeat (255) tick();
      check("wd_not_yet", 32'(panel_error), 32'h0);
      check("wd_rst_hi", 32'(vm_rst), 32'h1);
      tick();
      check("wd_err", 32'(panel_error), 32'h4);
      check("wd_rst_lo1", 32'(vm_rst), 32'h0);
      tick();
      check("wd_err_off", 32'(panel_error), 32'h0);
      check("wd_rst_lo2", 32'(vm_rst), 32'h0);
      tick();
      check("wd_rst_back", 32'(vm_rst), 32'h1);
      tick();
      check("wd_release", 32'(grant), 32'h0);
      check("wd_idle", 32'(busy), 32'h0);

      // Done on the expiry cycle: ptr=3, panel 3 granted.
      req = 4'b1000;
      tick();
      check("race_grant", 32'(grant), 32'h8);
      req = 4'b0000;
      tick();
      repeat (255) tick();
      vm_done = 1'b1;
      tick();
      vm_done = 1'b0;
      check("race_done", 32'(panel_done), 32'h8);
      check("race_err", 32'(panel_error), 32'h0);
      check("race_rst", 32'(vm_rst), 32'h1);
      tick();
      check("race_rst2", 32'(vm_rst), 32'h1);
      tick();
      check("race_release", 32'(grant), 32'h0);

      // Async reset mid-session, between clock edges.
      req = 4'b0001;
      tick();
      check("ar_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      tick();
      panel_one = 4'b0001;
      tick();
      check("ar_en_one", 32'(vm_en_one), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("ar_grant0", 32'(grant), 32'h0);
      check("ar_busy0", 32'(busy), 32'h0);
      check("ar_en0", 32'({vm_en_one, vm_en_two, vm_en_five}), 32'h0);
      check("ar_vm_rst", 32'(vm_rst), 32'h1);
      panel_one = 4'b0000;
      #1 rst = 1'b1;
      tick();
      check("ar_idle", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
